// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants used by the fetch stage and its IF/ID register.
package mips_pkg;
    localparam int unsigned        INSTR_W   = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0]        PC_INCR   = 32'd4;
endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction memory port and IF/ID outputs.
interface instruction_fetch_stage_if #(
    parameter int unsigned IMEM_ADDR_W = 13
);
    logic                   stall;
    logic                   branch_taken;
    logic [31:0]            branch_target;
    logic                   jump;
    logic [31:0]            jump_target;
    logic [IMEM_ADDR_W-1:0] imem_addr;
    logic [31:0]            imem_instr;
    logic [31:0]            pc;
    logic [31:0]            ifid_instr;
    logic [31:0]            ifid_pc_plus4;
    logic                   ifid_valid;
    logic                   fetch_fault;

    modport master (
        output stall, branch_taken, branch_target, jump, jump_target, imem_instr,
        input  imem_addr, pc, ifid_instr, ifid_pc_plus4, ifid_valid, fetch_fault
    );

    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_target, imem_instr,
        output imem_addr, pc, ifid_instr, ifid_pc_plus4, ifid_valid, fetch_fault
    );
endinterface

// File: rtl/ifid_register.sv
// IF/ID pipeline register: flush inserts a NOP bubble, hold freezes contents.
module ifid_register
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_flush,
    input  logic               i_hold,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [31:0]        i_pc_plus4,
    output logic [INSTR_W-1:0] o_instr,
    output logic [31:0]        o_pc_plus4,
    output logic               o_valid
);
    logic [INSTR_W-1:0] r_instr;
    logic [31:0]        r_pc_plus4;
    logic               r_valid;

    // Flush outranks hold so a redirect during a stall still squashes.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= 32'h0000_0000;
            r_valid    <= 1'b0;
        end else if (!i_hold) begin
            r_instr    <= i_instr;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b1;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;
endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: PC register, next-PC select and IF/ID capture.
// Optional FETCH_ALIGN_CHECK_EN: word-align redirect targets and flag a sticky fetch_fault.
module instruction_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned IMEM_ADDR_W = 13
) (
    input logic                      CLOCK,
    input logic                      RESET,
    instruction_fetch_stage_if.slave bus
);
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] w_pc_plus4;
    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_target_pc;
    logic        w_fault;

    assign w_pc_plus4 = r_pc + PC_INCR;
    assign w_redirect = bus.branch_taken | bus.jump;
    // The EX-stage branch is older than the ID-stage jump, so it wins.
    assign w_target   = bus.branch_taken ? bus.branch_target : bus.jump_target;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_fault;

    assign w_target_pc = {w_target[31:2], 2'b00};

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_fault <= 1'b0;
        end else if (w_redirect && (w_target[1:0] != 2'b00)) begin
            r_fault <= 1'b1;
        end
    end

    assign w_fault = r_fault;
`else
    assign w_target_pc = w_target;
    assign w_fault     = 1'b0;
`endif

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (w_redirect) begin
            w_pc_next = w_target_pc;
        end else if (bus.stall) begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    ifid_register u_ifid (
        .clk       (CLOCK),
        .rst       (RESET),
        .i_flush   (w_redirect),
        .i_hold    (bus.stall),
        .i_instr   (bus.imem_instr),
        .i_pc_plus4(w_pc_plus4),
        .o_instr   (bus.ifid_instr),
        .o_pc_plus4(bus.ifid_pc_plus4),
        .o_valid   (bus.ifid_valid)
    );

    assign bus.pc          = r_pc;
    assign bus.imem_addr   = r_pc[IMEM_ADDR_W-1:0];
    assign bus.fetch_fault = w_fault;
endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Fetch stage of the MIPS pipeline: holds the program counter, drives the address of the instruction memory, selects the next PC (sequential, jump, or taken branch), and registers the fetched word into the IF/ID pipeline register. The instruction memory is read combinationally, so the instruction for the current PC is captured at the next rising edge. The stage honours stall requests from the hazard unit and squashes the wrong-path instruction on redirects.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- IMEM_ADDR_W, 13, width of the byte address presented to instruction memory

- CLOCK  in  1  rising-edge clock
- RESET  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: hold PC and IF/ID contents
- branch_taken  in  1  EX stage: branch resolved taken
- branch_target  in  32  EX stage: branch destination byte address
- jump  in  1  ID stage: j/jal/jr decoded
- jump_target  in  32  ID stage: jump destination byte address
- imem_addr  out  IMEM_ADDR_W  byte address to instruction memory, equals pc[IMEM_ADDR_W-1:0]
- imem_instr  in  32  instruction word returned combinationally by instruction memory
- pc  out  32  current fetch PC
- ifid_instr  out  32  IF/ID instruction
- ifid_pc_plus4  out  32  IF/ID return/link address (fetch PC + 4)
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- fetch_fault  out  1  misaligned redirect target detected (see Configuration)

## Operation
- Next-PC priority per cycle: RESET > branch_taken > jump > stall > sequential (pc + 4).
- branch_taken outranks jump: the branch is older (EX) than the jump (ID).
- Redirect (branch_taken or jump): PC <= target; IF/ID <= NOP (32'h0000_0000), ifid_valid <= 0, ifid_pc_plus4 <= 0. Redirect overrides stall.
- Stall without redirect: PC, ifid_instr, ifid_pc_plus4, ifid_valid all hold.
- Sequential: PC <= pc + 4; ifid_instr <= imem_instr; ifid_pc_plus4 <= pc + 4; ifid_valid <= 1.
- Arithmetic: pc + 4 is modulo 2^32 (32'hFFFF_FFFC wraps to 0). imem_addr truncates; PCs beyond memory size alias.
- Reset: pc = RESET_PC, ifid_instr = 0, ifid_pc_plus4 = 0, ifid_valid = 0, fetch_fault = 0. Reset asserted mid-stall or mid-redirect wins unconditionally.

## Timing
- imem_addr changes only at rising edges (registered PC); no combinational path from any input to imem_addr or pc.
- Fetch latency: instruction at PC appears on ifid_instr one edge after PC is presented.
- Redirect penalty: exactly one bubble (ifid_valid = 0 for one cycle), target instruction in IF/ID on the second edge after redirect asserted.
- First valid IF/ID instruction: second edge after RESET deasserts, provided no stall.
- stall held N cycles freezes the stage exactly N cycles.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: on a redirect whose target[1:0] != 0, fetch_fault <= 1 (sticky until RESET) and PC <= {target[31:2], 2'b00}.
- Undefined: target taken as-is, low bits passed through to imem_addr; fetch_fault tied to 0.

## Structure
- Shared package mips_pkg: INSTR_W = 32, NOP_INSTR = 32'h0000_0000, PC_INCR = 4.
- One sub-module: ifid_register (instr, pc_plus4, valid with hold/flush controls); PC register and next-PC mux stay in the top.

## Test plan
- Reset with RESET_PC = 0, release, no stall -> imem_addr 0,4,8,12 on successive cycles; ifid_valid 0 then 1 from second edge, ifid_pc_plus4 = 4,8,12.
- stall high 3 cycles at pc = 8 -> pc stays 8, IF/ID contents unchanged 3 cycles, resume at 12.
- jump = 1, jump_target = 32'h40 at pc = 12 -> next pc 32'h40, one bubble, then ifid_instr = word at 0x40, ifid_pc_plus4 = 32'h44.
- branch_taken (target 32'h80) and jump (target 32'h40) together while stall = 1 -> pc = 32'h80, ifid_valid = 0.
- pc forced to 32'hFFFF_FFFC sequentially -> next pc 0, ifid_pc_plus4 = 0.
- With FETCH_ALIGN_CHECK_EN, jump_target = 32'h42 -> pc = 32'h40, fetch_fault = 1 and sticky until RESET; without macro -> pc = 32'h42, fetch_fault = 0.
